// File: rtl/divu_32by16_seq.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor.
// Uses restoring shift-subtract and retires one quotient bit per clock.
module divu_32by16_seq #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              busy,
    output logic              done,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_zero,
    output logic [1:0]        o_dbg_state
);

    // Handshake: start is sampled on a rising edge and accepted only in IDLE.
    // busy is high from the accepting edge until done rises. done is a
    // one-cycle pulse, and the results stay put until the next accept.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int CW = $clog2(2*DW);

    state_t            r_state;
    state_t            w_next_state;

    logic [2*DW-1:0]   r_work;
    logic [DW:0]       r_prem;
    logic [DW-1:0]     r_divisor;
    logic [CW-1:0]     r_count;
    logic              r_dz_pend;
    logic              r_busy;
    logic              r_done;
    logic              r_div_zero;
    logic [2*DW-1:0]   r_quotient;
    logic [DW-1:0]     r_remainder;

    logic              w_accept;
    logic              w_last;
    logic [DW:0]       w_trial;
    logic [DW:0]       w_diff;
    logic              w_ge;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_count == CW'(2*DW-1));

    // The partial remainder always stays below the divisor, so its top bit
    // is zero between steps. The DW+1-bit trial therefore cannot overflow.
    assign w_trial  = {r_prem[DW-1:0], r_work[2*DW-1]};
    assign w_ge     = r_prem[DW] | (w_trial >= {1'b0, r_divisor});
    assign w_diff   = w_trial - {1'b0, r_divisor};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (divisor == '0) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // The dividend shift register doubles as the quotient: each step moves
    // out one dividend bit at the top and brings one quotient bit in at the bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work      <= '0;
            r_prem      <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_dz_pend   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_count   <= '0;
                        r_divisor <= divisor;
                        if (divisor == '0) begin
                            r_work    <= '1;
                            r_prem    <= {1'b0, dividend[DW-1:0]};
                            r_dz_pend <= 1'b1;
                        end else begin
                            r_work    <= dividend;
                            r_prem    <= '0;
                            r_dz_pend <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_prem  <= w_ge ? w_diff : w_trial;
                    r_work  <= {r_work[2*DW-2:0], w_ge};
                    r_count <= r_count + CW'(1);
                end
                S_FIN: begin
                    r_busy      <= 1'b0;
                    r_quotient  <= r_work;
                    r_remainder <= r_prem[DW-1:0];
                    r_div_zero  <= r_dz_pend;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divu_32by16_seq.sv
// Self-checking bench for divu_32by16_seq: directed vectors, corner
// sequences and random operands compared against an arithmetic reference.
module tb_divu_32by16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    divu_32by16_seq #(.DW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; division by zero is defined by the block.
    task automatic ref_div(input logic [31:0] a, input logic [15:0] b,
                           output logic [31:0] q, output logic [15:0] r,
                           output logic dz, output int lat);
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            dz = 1'b1;
            lat = 1;
        end else begin
            logic [31:0] rr;
            q = a / {16'd0, b};
            rr = a % {16'd0, b};
            r = rr[15:0];
            dz = 1'b0;
            lat = 33;
        end
    endtask

    // Starts one operation and scrambles the operand inputs right after the
    // accepting edge. lat counts edges from acceptance to done, capped at 100.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                          output int lat, output int busy_gaps);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = 16'($urandom);
        busy_gaps = busy ? 0 : 1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
    endtask

    vec_t        vecs[6];
    int          lat;
    int          gaps;
    int          extra;
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    int          elat;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;

        vecs[0] = '{32'd1000,       16'd7,      32'd142,       16'd6,      1'b0, 33};
        vecs[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001, 16'd0,      1'b0, 33};
        vecs[2] = '{32'h1234_5678,  16'd1,      32'h1234_5678, 16'd0,      1'b0, 33};
        vecs[3] = '{32'd5,          16'd9,      32'd0,         16'd5,      1'b0, 33};
        vecs[4] = '{32'h0000_1234,  16'd0,      32'hFFFF_FFFF, 16'h1234,   1'b1, 1};
        vecs[5] = '{32'd100,        16'd10,     32'd10,        16'd0,      1'b0, 33};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_zero", div_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, gaps);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_div_zero", i), div_zero, vecs[i].dz);
            check($sformatf("vec%0d_busy_gaps", i), gaps, 0);
            check($sformatf("vec%0d_busy_at_done", i), busy, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("hold_quotient", quotient, 32'd10);
        check("hold_remainder", remainder, 16'd0);
        check("hold_done_low", done, 0);

        // start pulses at cycle 10 (CALC) and cycle 33 (FIN) must be ignored
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        extra = 0;
        while (lat < 100 && extra == 0) begin
            @(negedge clk);
            if (lat + 1 == 10 || lat + 1 == 33) begin
                start = 1'b1;
                dividend = 32'd50;
                divisor = 16'd5;
            end else begin
                start = 1'b0;
                dividend = $urandom;
                divisor = 16'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) extra = 1;
        end
        start = 1'b0;
        check("ign_latency", lat, 33);
        check("ign_quotient", quotient, 32'd142);
        check("ign_remainder", remainder, 16'd6);
        check("ign_div_zero", div_zero, 0);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
            if (busy) extra++;
        end
        check("ign_no_second_op", extra, 0);

        // reset in the middle of an operation aborts it without a done pulse
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_zero", div_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
            if (busy) extra++;
        end
        check("midrst_no_done", extra, 0);
        run_op(32'd81, 16'd9, lat, gaps);
        check("post_rst_latency", lat, 33);
        check("post_rst_quotient", quotient, 32'd9);
        check("post_rst_remainder", remainder, 16'd0);
        check("post_rst_div_zero", div_zero, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [15:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'($urandom);
                default: begin
                    b = 16'($urandom_range(1000, 65535));
                    a = 32'($urandom_range(0, 999));
                end
            endcase
            ref_div(a, b, eq, er, edz, elat);
            run_op(a, b, lat, gaps);
            check($sformatf("rnd%0d_latency", i), lat, elat);
            check($sformatf("rnd%0d_quotient", i), quotient, eq);
            check($sformatf("rnd%0d_remainder", i), remainder, er);
            check($sformatf("rnd%0d_div_zero", i), div_zero, edz);
            check($sformatf("rnd%0d_busy_gaps", i), gaps, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
